// File: rtl/ctrl_step_sequencer.sv
// Control-step sequencer: fetch T0..T3, then ld/ldi/st execute steps T4..T7 selected by the IR opcode.
// Memory steps stall on mem_ready and abort to IDLE with a sticky fault after MEM_TIMEOUT wait cycles.
module ctrl_step_sequencer #(
  parameter int                OPC_W       = 5,
  parameter int                ALU_OP_W    = 4,
  parameter logic [ALU_OP_W-1:0] ALU_ADD   = 4'b0010,
  parameter logic [OPC_W-1:0]  OP_LD       = 5'd0,
  parameter logic [OPC_W-1:0]  OP_LDI      = 5'd1,
  parameter logic [OPC_W-1:0]  OP_ST       = 5'd2,
  parameter int                TO_W        = 8,
  parameter int                MEM_TIMEOUT = 16,
  parameter int                CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [OPC_W-1:0]    ir_opcode,
  input  logic                mem_ready,
  output logic                pc_out,
  output logic                z_low_out,
  output logic                mdr_out,
  output logic                mar_in,
  output logic                z_in,
  output logic                pc_in,
  output logic                mdr_in,
  output logic                ir_in,
  output logic                y_in,
  output logic                c_out,
  output logic                inc_pc,
  output logic                read,
  output logic                write,
  output logic                gra,
  output logic                grb,
  output logic                r_in,
  output logic                r_out,
  output logic                ba_out,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [3:0]          step,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                fault,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [3:0]       state, state_nx, boundary;
  logic [OPC_W-1:0] op_q;
  logic [TO_W-1:0]  wait_cnt;
  logic             known_op, is_ld, is_ldi, is_st;
  logic             mem_wait, timeout, last_step;

  assign known_op = (ir_opcode == OP_LD) || (ir_opcode == OP_LDI) || (ir_opcode == OP_ST);
  assign is_ld    = (op_q == OP_LD);
  assign is_ldi   = (op_q == OP_LDI);
  assign is_st    = !is_ld && !is_ldi;

  // Only these steps wait on memory; mem_ready is ignored everywhere else.
  assign mem_wait  = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);
  assign timeout   = mem_wait && !mem_ready && (wait_cnt == TO_LAST);
  assign last_step = (state == S_T5 && is_ldi) || (state == S_T7 && is_ld) ||
                     (state == S_T7 && is_st && mem_ready);
  assign boundary  = run ? S_T0 : S_IDLE;

  assign instr_done = last_step;
  assign illegal_op = (state == S_T3) && !known_op;
  assign step       = state;

  // NOTE: every output of always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (run && !fault) state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   if (mem_ready) state_nx = S_T2;
      S_T2:   state_nx = S_T3;
      S_T3:   state_nx = known_op ? S_T4 : boundary;
      S_T4:   state_nx = S_T5;
      S_T5:   state_nx = is_ldi ? boundary : S_T6;
      S_T6:   if (!is_ld || mem_ready) state_nx = S_T7;
      S_T7:   if (is_ld || mem_ready) state_nx = boundary;
      default: state_nx = S_IDLE;
    endcase
    if (timeout) state_nx = S_IDLE;
  end

  always_comb begin
    {pc_out, z_low_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in,
     c_out, inc_pc, read, write, gra, grb, r_in, r_out, ba_out} = '0;
    alu_op = '0;
    case (state)
      S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
      S_T1: begin z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
      S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_T3: begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
      S_T4: begin c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
      S_T5: begin
        z_low_out = 1'b1;
        if (is_ldi) begin gra = 1'b1; r_in = 1'b1; end
        else        mar_in = 1'b1;
      end
      S_T6: begin
        mdr_in = 1'b1;
        if (is_ld) read = 1'b1;
        else begin gra = 1'b1; r_out = 1'b1; end
      end
      S_T7: begin
        if (is_ld) begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else       write = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      fault    <= 1'b0;
      retired  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_T3 && known_op) op_q <= ir_opcode;
      // Any step change restarts the wait count, so each memory step gets a fresh budget.
      if (state_nx != state)           wait_cnt <= '0;
      else if (mem_wait && !mem_ready) wait_cnt <= wait_cnt + TO_W'(1);
      if (timeout)   fault   <= 1'b1;
      if (last_step) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Lock-step scoreboard bench: stimulus pushes the hand-derived expected outputs for each cycle,
// a negedge monitor pops and compares them against the sequencer outputs.
module tb_ctrl_step_sequencer;

  localparam logic [4:0] LD = 5'd0, LDI = 5'd1, ST = 5'd2, XOP = 5'd31;

  localparam logic [17:0] PC_OUT = 18'd1 << 17, Z_LOW  = 18'd1 << 16, MDR_OUT = 18'd1 << 15;
  localparam logic [17:0] MAR_IN = 18'd1 << 14, Z_IN   = 18'd1 << 13, PC_IN   = 18'd1 << 12;
  localparam logic [17:0] MDR_IN = 18'd1 << 11, IR_IN  = 18'd1 << 10, Y_IN    = 18'd1 << 9;
  localparam logic [17:0] C_OUT  = 18'd1 << 8,  INC_PC = 18'd1 << 7,  READ    = 18'd1 << 6;
  localparam logic [17:0] WRITE  = 18'd1 << 5,  GRA    = 18'd1 << 4,  GRB     = 18'd1 << 3;
  localparam logic [17:0] R_IN   = 18'd1 << 2,  R_OUT  = 18'd1 << 1,  BA_OUT  = 18'd1 << 0;

  localparam logic [17:0] V_T0  = PC_OUT | MAR_IN | INC_PC | Z_IN;
  localparam logic [17:0] V_T1  = Z_LOW | PC_IN | READ | MDR_IN;
  localparam logic [17:0] V_T2  = MDR_OUT | IR_IN;
  localparam logic [17:0] V_T3  = GRB | BA_OUT | Y_IN;
  localparam logic [17:0] V_T4  = C_OUT | Z_IN;
  localparam logic [17:0] V_T5M = Z_LOW | MAR_IN;
  localparam logic [17:0] V_T5I = Z_LOW | GRA | R_IN;
  localparam logic [17:0] V_T6L = READ | MDR_IN;
  localparam logic [17:0] V_T6S = GRA | R_OUT | MDR_IN;
  localparam logic [17:0] V_T7L = MDR_OUT | GRA | R_IN;
  localparam logic [17:0] V_T7S = WRITE;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  step;
    logic [17:0] strb;
    logic [3:0]  alu;
    logic        done;
    logic        ill;
    logic        fault;
    logic [15:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, run, mem_ready;
  logic [4:0]  ir_opcode;
  logic        pc_out, z_low_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in;
  logic        c_out, inc_pc, read, write, gra, grb, r_in, r_out, ba_out;
  logic [3:0]  alu_op, step;
  logic        instr_done, illegal_op, fault;
  logic [15:0] retired;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] cyc_id = '0;
  logic [15:0] exp_ret = '0;
  logic        exp_fault = 1'b0;

  ctrl_step_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
    .pc_out(pc_out), .z_low_out(z_low_out), .mdr_out(mdr_out), .mar_in(mar_in), .z_in(z_in),
    .pc_in(pc_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .c_out(c_out), .inc_pc(inc_pc),
    .read(read), .write(write), .gra(gra), .grb(grb), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .alu_op(alu_op), .step(step), .instr_done(instr_done), .illegal_op(illegal_op),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, id, act, exp);
  endtask

  // Monitor: samples mid-cycle, away from the rising edge where state moves.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("step",       e.id, 32'(step), 32'(e.step));
      check("strobes",    e.id, 32'({pc_out, z_low_out, mdr_out, mar_in, z_in, pc_in, mdr_in,
                                     ir_in, y_in, c_out, inc_pc, read, write, gra, grb, r_in,
                                     r_out, ba_out}), 32'(e.strb));
      check("alu_op",     e.id, 32'(alu_op), 32'(e.alu));
      check("instr_done", e.id, 32'(instr_done), 32'(e.done));
      check("illegal_op", e.id, 32'(illegal_op), 32'(e.ill));
      check("fault",      e.id, 32'(fault), 32'(e.fault));
      check("retired",    e.id, 32'(retired), 32'(e.ret));
    end
  end

  // One clock cycle: drive inputs just after the rising edge and queue what the DUT must show.
  task automatic tick(input logic r, input logic rdy, input logic [4:0] op, input logic [3:0] s,
                      input logic [17:0] v, input logic add, input logic done, input logic ill);
    exp_t e;
    run = r; mem_ready = rdy; ir_opcode = op;
    e = '{id: cyc_id, step: s, strb: v, alu: add ? 4'b0010 : 4'b0000, done: done, ill: ill,
          fault: exp_fault, ret: exp_ret};
    sb.push_back(e);
    cyc_id++;
    @(posedge clk); #1;
    if (done) exp_ret++;
  endtask

  task automatic reset_cycles(input int n);
    reset_n = 1'b0;
    exp_ret = '0; exp_fault = 1'b0;
    repeat (n) tick(1'b0, 1'b0, XOP, 4'd0, '0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic idle(input logic r);
    tick(r, 1'b1, XOP, 4'd0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // T0..T2 with memory answering at once; T3 is issued by the caller.
  task automatic fetch(input logic r);
    tick(r, 1'b1, XOP, 4'd1, V_T0, 1'b1, 1'b0, 1'b0);
    tick(r, 1'b1, XOP, 4'd2, V_T1, 1'b0, 1'b0, 1'b0);
    tick(r, 1'b1, XOP, 4'd3, V_T2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; ir_opcode = XOP;
    @(posedge clk); #1;
    reset_cycles(2);

    // ld, one cycle per step, run dropped on the final step
    idle(1'b1);
    fetch(1'b1);
    tick(1'b1, 1'b1, LD,  4'd4, V_T3,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd5, V_T4,  1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd6, V_T5M, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd7, V_T6L, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, XOP, 4'd8, V_T7L, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // ldi ends at T5 and flows straight into st; st write waits three cycles for ready
    idle(1'b1);
    fetch(1'b1);
    tick(1'b1, 1'b1, LDI, 4'd4, V_T3,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd5, V_T4,  1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd6, V_T5I, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, XOP, 4'd1, V_T0,  1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd2, V_T1,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd3, V_T2,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, ST,  4'd4, V_T3,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd5, V_T4,  1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd6, V_T5M, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, XOP, 4'd7, V_T6S, 1'b0, 1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0, XOP, 4'd8, V_T7S, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, XOP, 4'd8, V_T7S, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // illegal opcode with run=1 restarts at T0; following ld has run dropped in T4
    idle(1'b1);
    fetch(1'b1);
    tick(1'b1, 1'b1, 5'd9, 4'd4, V_T3, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, XOP, 4'd1, V_T0,  1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, XOP, 4'd2, V_T1,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, XOP, 4'd2, V_T1,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd2, V_T1,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd3, V_T2,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, LD,  4'd4, V_T3,  1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, XOP, 4'd5, V_T4,  1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, XOP, 4'd6, V_T5M, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, XOP, 4'd7, V_T6L, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, XOP, 4'd7, V_T6L, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, XOP, 4'd8, V_T7L, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // illegal opcode with run=0 returns to IDLE
    idle(1'b1);
    fetch(1'b0);
    tick(1'b0, 1'b1, XOP, 4'd4, V_T3, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // async reset while an ld sits in T6
    idle(1'b1);
    fetch(1'b1);
    tick(1'b1, 1'b1, LD,  4'd4, V_T3,  1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd5, V_T4,  1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd6, V_T5M, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, XOP, 4'd7, V_T6L, 1'b0, 1'b0, 1'b0);
    reset_cycles(2);

    // ready on the 16th wait cycle completes; 16 cycles without ready faults
    idle(1'b1);
    tick(1'b1, 1'b1, XOP, 4'd1, V_T0, 1'b1, 1'b0, 1'b0);
    repeat (15) tick(1'b1, 1'b0, XOP, 4'd2, V_T1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd2, V_T1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd3, V_T2, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, LDI, 4'd4, V_T3, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd5, V_T4, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd6, V_T5I, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, XOP, 4'd1, V_T0, 1'b1, 1'b0, 1'b0);
    repeat (16) tick(1'b1, 1'b0, XOP, 4'd2, V_T1, 1'b0, 1'b0, 1'b0);
    exp_fault = 1'b1;
    repeat (4) idle(1'b1);
    reset_cycles(1);
    idle(1'b1);
    fetch(1'b0);
    tick(1'b0, 1'b1, LDI, 4'd4, V_T3,  1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, XOP, 4'd5, V_T4,  1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, XOP, 4'd6, V_T5I, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
